// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant held until the owner releases.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_8 #(
  parameter int N        = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // The pointer arithmetic relies on natural 3-bit wrap, so the geometry is fixed.
  if (N != 8 || IDW != 3 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_cfg
    $error("rr_arbiter_8: unsupported parameter combination");
  end

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IDW-1:0] ptr_q, ptr_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // Rotate so that bit 0 of req_rot is requester ptr; the lowest set bit then wins.
  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_shift;
  logic [N-1:0]   req_rot;
  logic [IDW-1:0] rot_off;
  logic [IDW-1:0] sel;
  logic           any_req;

  function automatic logic [IDW-1:0] lowest_set(input logic [N-1:0] v);
    lowest_set = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDW'(i);
    end
  endfunction

  always_comb begin
    req_dbl   = {req, req};
    req_shift = req_dbl >> ptr_q;
    req_rot   = req_shift[N-1:0];
    rot_off   = lowest_set(req_rot);
    sel       = ptr_q + rot_off;
    any_req   = |req;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred on unassigned paths.
    state_d       = state_q;
    gnt_d         = gnt_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    ptr_d         = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
    timeout_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d       = GRANT;
          gnt_d         = N'(1) << sel;
          grant_id_d    = sel;
          grant_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d    = '0;
`endif
        end
      end

      GRANT: begin
        if (!req[grant_id_q]) begin
          state_d       = IDLE;
          gnt_d         = '0;
          grant_valid_d = 1'b0;
          ptr_d         = grant_id_q + 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        // Owner still requesting at the hold limit: take the grant away and flag it.
        else if (hold_cnt_q == HOLD_LAST) begin
          state_d       = IDLE;
          gnt_d         = '0;
          grant_valid_d = 1'b0;
          ptr_d         = grant_id_q + 1'b1;
          timeout_d     = 1'b1;
        end else begin
          hold_cnt_d    = hold_cnt_q + 8'd1;
        end
`endif
      end

      default: begin
        state_d       = IDLE;
        gnt_d         = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q    <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q    <= hold_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: a behavioural model predicts every cycle's outputs,
// a separate monitor compares them; directed scenarios add fixed-value checks.
module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  rr_arbiter_8 #(.N(8), .IDW(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt         (gnt),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sb_on  = 1'b0;

  // Model state: current owner (-1 = none), next scan start, last granted id, hold length.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_last  = 0;
  int m_hold  = 0;
  bit m_tmo   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_last  = 0;
    m_hold  = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    bit found;
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (m_ptr + k) % 8;
        if (!found && r[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_last  = idx;
          m_hold  = 0;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end
`ifdef ARB_TIMEOUT_EN
    else if (m_hold == MAX_HOLD - 1) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_tmo   = 1'b1;
    end else begin
      m_hold++;
    end
`endif
  endtask

  // Predictor: at each edge the model consumes the sampled req and queues the outcome.
  always @(posedge clk) begin
    if (sb_on && !rst) begin
      exp_t e;
      model_step(req);
      e.gnt   = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      e.id    = 3'(m_last);
      e.valid = (m_owner >= 0);
      e.tmo   = m_tmo;
      exp_q.push_back(e);
    end
  end

  // Monitor: samples just after the edge and retires one prediction per cycle.
  always @(posedge clk) begin
    if (sb_on && !rst) begin
      #1;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_gnt", 32'(gnt), 32'(e.gnt));
        check("sb_grant_valid", 32'(grant_valid), 32'(e.valid));
        check("sb_grant_id", 32'(grant_id), 32'(e.id));
        check("sb_timeout", 32'(timeout), 32'(e.tmo));
        check("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("inv_gnt_at_id", 32'(gnt[grant_id]), 32'(grant_valid));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    sb_on = 1'b0;
    rst   = 1'b1;
    req   = 8'h00;
    repeat (2) step();
    model_reset();
    exp_q.delete();
    rst   = 1'b0;
    sb_on = 1'b1;
  endtask

  task automatic check_now(input string name, input logic [7:0] g, input logic [2:0] id,
                           input logic v);
    check({name, "_gnt"}, 32'(gnt), 32'(g));
    check({name, "_id"}, 32'(grant_id), 32'(id));
    check({name, "_valid"}, 32'(grant_valid), 32'(v));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int seq[$];
    int r;

    // Reset values.
    rst = 1'b1;
    req = 8'h00;
    #3;
    check_now("reset", 8'h00, 3'd0, 1'b0);
    check("reset_timeout", 32'(timeout), 32'd0);
    do_reset();

    // Basic grant and release.
    req = 8'b0000_0100;
    step();
    check_now("basic_grant", 8'h04, 3'd2, 1'b1);
    step();
    step();
    check_now("basic_hold", 8'h04, 3'd2, 1'b1);
    req = 8'h00;
    step();
    check_now("basic_release", 8'h00, 3'd2, 1'b0);

    // Fairness: every requester served in turn with one idle cycle in between.
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 10; g++) begin
      step();
      seq.push_back(int'(grant_id));
      check("fair_valid", 32'(grant_valid), 32'd1);
      check("fair_id", 32'(grant_id), 32'(g % 8));
      if (m_owner >= 0) req[m_owner] = 1'b0;
      step();
      check("fair_idle", 32'(grant_valid), 32'd0);
      req = 8'hFF;
    end
    check("fair_count", 32'(seq.size()), 32'd10);

    // Pointer wrap past requester 7.
    do_reset();
    req = 8'b0010_0000;
    step();
    check_now("wrap_g5", 8'h20, 3'd5, 1'b1);
    req = 8'h00;
    step();
    req = 8'b0000_0011;
    step();
    check_now("wrap_g0", 8'h01, 3'd0, 1'b1);
    req = 8'h00;
    step();
    req = 8'b0000_0011;
    step();
    check_now("wrap_g1", 8'h02, 3'd1, 1'b1);

    // No preemption, then simultaneous drop with other requests pending.
    do_reset();
    req = 8'b0000_1000;
    step();
    check_now("nopre_g3", 8'h08, 3'd3, 1'b1);
    req = 8'b0100_1010;
    step();
    check_now("nopre_hold", 8'h08, 3'd3, 1'b1);
    req = 8'b0100_0010;
    step();
    check_now("nopre_idle", 8'h00, 3'd3, 1'b0);
    step();
    check_now("nopre_g6", 8'h40, 3'd6, 1'b1);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 8'b0001_0000;
    step();
    check_now("mid_g4", 8'h10, 3'd4, 1'b1);
    sb_on = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_now("mid_rst", 8'h00, 3'd0, 1'b0);
    check("mid_rst_timeout", 32'(timeout), 32'd0);
    step();
    req = 8'hFF;
    model_reset();
    exp_q.delete();
    rst   = 1'b0;
    sb_on = 1'b1;
    step();
    check_now("mid_after", 8'h01, 3'd0, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // Forced release after MAX_HOLD cycles, then re-grant rules.
    do_reset();
    req = 8'b0000_0100;
    for (int c = 0; c < MAX_HOLD; c++) begin
      step();
      check("tmo_hold_gnt", 32'(gnt), 32'h04);
      check("tmo_hold_pulse", 32'(timeout), 32'd0);
    end
    step();
    check_now("tmo_forced", 8'h00, 3'd2, 1'b0);
    check("tmo_pulse", 32'(timeout), 32'd1);
    step();
    check_now("tmo_regrant_alone", 8'h04, 3'd2, 1'b1);
    check("tmo_pulse_gone", 32'(timeout), 32'd0);
    repeat (MAX_HOLD - 1) step();
    step();
    check("tmo_pulse2", 32'(timeout), 32'd1);
    req = 8'b0000_1100;
    step();
    check_now("tmo_other_first", 8'h08, 3'd3, 1'b1);
`endif

    // Randomized traffic checked only by the scoreboard.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      r = $urandom_range(0, 9);
      if (r < 2) req = 8'($urandom);
      else if (r < 4 && m_owner >= 0) req[m_owner] = 1'b0;
      else if (r == 4) req = 8'h00;
      else if (r == 5) req[$urandom_range(0, 7)] = 1'b1;
    end
    req = 8'h00;
    repeat (3) step();
    sb_on = 1'b0;
    step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
